pingpong_fill_ctrl: RTL and testbench
=====================================

PINGPONG_FILL_CTRL -- requirements
Module: pingpong_fill_ctrl

Interface
REQ-001 SHALL provide parameter KT_W, default 12: width of the K-tile count and of the fill index.
REQ-002 SHALL provide parameter CNT_W, default 32: width of the wait-cycle counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a fill sequence; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  level; terminates any sequence.
REQ-007 SHALL have port KT  input  KT_W  number of K tiles to load; sampled on an accepted start.
REQ-008 SHALL have port fill_req  output  1  request to the loader to fill bank fill_bank with tile fill_idx.
REQ-009 SHALL have port fill_bank  output  1  target bank: 0 = ping, 1 = pong.
REQ-010 SHALL have port fill_idx  output  KT_W  K-tile index being loaded.
REQ-011 SHALL have port fill_done  input  1  loader pulse marking the completion of the outstanding request.
REQ-012 SHALL have port rel_ping  input  1  consumer (scheduler) pulse that frees the ping bank.
REQ-013 SHALL have port rel_pong  input  1  consumer pulse that frees the pong bank.
REQ-014 SHALL have port valid_ping  output  1  ping bank holds unconsumed data; drives the scheduler valid_A_ping/valid_B_ping.
REQ-015 SHALL have port valid_pong  output  1  pong bank holds unconsumed data.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at the end of a sequence.
REQ-018 SHALL have port wait_cycles  output  CNT_W  count of cycles spent blocked on a full bank.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT_FILL and DRAIN.
REQ-020 IDLE with start and KT!=0 SHALL latch KT, set fill_idx=0 and target bank=0, clear wait_cycles, and go to ISSUE.
REQ-021 IDLE with start and KT==0 SHALL pulse done on the next cycle, issue no request, and stay in IDLE.
REQ-022 In ISSUE, if the target bank's valid bit is 0, the block SHALL assert fill_req, registered, on the next cycle and go to WAIT_FILL.
REQ-023 In ISSUE, if the target bank's valid bit is 1, the block SHALL stay in ISSUE and increment wait_cycles, saturating at all-ones.
REQ-024 In WAIT_FILL, fill_req, fill_bank and fill_idx SHALL hold stable until fill_done arrives.
REQ-025 On fill_done the block SHALL, in the same edge: deassert fill_req; set the target bank's valid bit; increment fill_idx; toggle the target bank.
REQ-026 After fill_done, the next state SHALL be DRAIN if the incremented fill_idx equals the latched KT, else ISSUE.
REQ-027 The block SHALL treat fill_done outside WAIT_FILL as having no effect.
REQ-028 rel_ping SHALL clear valid_ping on the next edge in any non-IDLE state; rel_pong SHALL likewise clear valid_pong.
REQ-029 A release of a bank that is already invalid SHALL be ignored.
REQ-030 When a release and ISSUE target the same bank in the same cycle, the release SHALL take effect first; the request SHALL then issue one cycle later.
REQ-031 When rel_ping and rel_pong arrive together, both SHALL apply.
REQ-032 DRAIN SHALL wait until valid_ping==0 and valid_pong==0, then pulse done and return to IDLE.
REQ-033 abort SHALL take priority over all other inputs in every state.
REQ-034 On abort the next edge SHALL go to IDLE and clear fill_req, valid_ping and valid_pong, with no done pulse.
REQ-035 A start received in a non-IDLE state SHALL be ignored.
REQ-036 fill_idx SHALL wrap modulo 2^KT_W; with KT=2^KT_W-1 the last index SHALL be 2^KT_W-2.

Reset
REQ-037 When rst is high at an edge, the block SHALL set: state=IDLE, fill_req=0, fill_bank=0, fill_idx=0, valid_ping=0, valid_pong=0, busy=0, done=0, wait_cycles=0.
REQ-038 rst mid-sequence SHALL behave as abort and additionally clear wait_cycles; an outstanding loader transaction is abandoned.

Configuration
REQ-039 With PPFC_PROTOCOL_CHECK_EN defined, the block SHALL add output proto_err (1 bit, sticky).
REQ-040 proto_err SHALL set on any of: release of an invalid bank; fill_done outside WAIT_FILL; start while busy.
REQ-041 proto_err SHALL clear only on rst or on an accepted start.
REQ-042 Without PPFC_PROTOCOL_CHECK_EN, port proto_err and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-043 Scenario: KT=4; fill_done 2 cycles after each fill_req; each bank released 3 cycles after it becomes valid -> requests (bank,idx) = (0,0) (1,1) (0,2) (1,3); done once; wait_cycles consistent with release timing.
REQ-044 Scenario: KT=3; no releases until 20 cycles after start -> after (0,0) and (1,1) the block stalls in ISSUE with wait_cycles incrementing every cycle; a rel_ping pulse leads to request (0,2) two edges later.
REQ-045 Scenario: KT=0 start -> done pulses on the next cycle; fill_req stays 0; busy stays 0.
REQ-046 Scenario: abort during WAIT_FILL at idx=1 -> on the next edge fill_req=0, valid_ping=0, valid_pong=0, state IDLE, no done; a new start with KT=2 runs cleanly from idx 0.
REQ-047 Scenario: release and ISSUE on the same bank in the same cycle, with rel_ping and rel_pong together -> both valids clear; the request issues exactly one cycle later.
REQ-048 Scenario: with PPFC_PROTOCOL_CHECK_EN, rel_pong while valid_pong=0 -> proto_err=1 and held; the next accepted start clears it.

Source files
------------

// File: rtl/pingpong_fill_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_fill_ctrl
//
// Purpose:
//   Sequences the loading of KT K-tiles into a two-bank (ping/pong) buffer.
//   Tiles are written alternately into bank 0 (ping) and bank 1 (pong). A
//   bank is refilled only after the consumer has released it. The block
//   counts the cycles it spends stalled on a full bank.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle pulse starting a sequence (honoured in IDLE only)
//   abort        level, terminates any sequence, highest priority
//   KT           number of tiles to load, sampled on an accepted start
//   fill_req     registered request to the loader
//   fill_bank    target bank of the request (0 = ping, 1 = pong)
//   fill_idx     tile index of the request
//   fill_done    loader pulse completing the outstanding request
//   rel_ping     consumer pulse freeing the ping bank
//   rel_pong     consumer pulse freeing the pong bank
//   valid_ping   ping bank holds unconsumed data
//   valid_pong   pong bank holds unconsumed data
//   busy         high whenever the controller is not IDLE
//   done         one-cycle pulse at the end of a completed sequence
//   wait_cycles  saturating count of cycles stalled on a full bank
//   proto_err    sticky protocol-violation flag (only with the macro below)
//
// Configuration:
//   PPFC_PROTOCOL_CHECK_EN  when defined, adds the proto_err output and the
//                           logic that detects protocol violations.
// ---------------------------------------------------------------------------
module pingpong_fill_ctrl #(
    parameter int KT_W  = 12,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [KT_W-1:0]  KT,
    output logic             fill_req,
    output logic             fill_bank,
    output logic [KT_W-1:0]  fill_idx,
    input  logic             fill_done,
    input  logic             rel_ping,
    input  logic             rel_pong,
    output logic             valid_ping,
    output logic             valid_pong,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] wait_cycles
`ifdef PPFC_PROTOCOL_CHECK_EN
    ,
    output logic             proto_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FILL, DRAIN} state_t;

    state_t            state_q;
    logic              fill_req_q;
    logic              fill_bank_q;
    logic [KT_W-1:0]   fill_idx_q;
    logic [KT_W-1:0]   kt_q;
    logic              valid_ping_q;
    logic              valid_pong_q;
    logic              done_q;
    logic [CNT_W-1:0]  wait_cycles_q;

    logic [KT_W-1:0]   fill_idx_d;
    logic [CNT_W-1:0]  wait_cycles_d;
    logic              target_valid;

    // Next tile index (wraps naturally at 2^KT_W), the saturating stall
    // count, and whether the bank we want to fill next is still occupied.
    always_comb begin
        fill_idx_d    = fill_idx_q + KT_W'(1);
        wait_cycles_d = (&wait_cycles_q) ? wait_cycles_q : wait_cycles_q + CNT_W'(1);
        target_valid  = fill_bank_q ? valid_pong_q : valid_ping_q;
    end

    // Main controller. Abort wins over everything except reset. Releases are
    // applied before the case statement so that a fill completing on the
    // same edge (a later assignment) can still set its own bank's valid bit.
    // ISSUE decides on the valid bit as it was this cycle, so a release of
    // the target bank delays the request by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fill_req_q    <= 1'b0;
            fill_bank_q   <= 1'b0;
            fill_idx_q    <= '0;
            kt_q          <= '0;
            valid_ping_q  <= 1'b0;
            valid_pong_q  <= 1'b0;
            done_q        <= 1'b0;
            wait_cycles_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q      <= IDLE;
                fill_req_q   <= 1'b0;
                valid_ping_q <= 1'b0;
                valid_pong_q <= 1'b0;
            end else begin
                if (state_q != IDLE) begin
                    if (rel_ping) valid_ping_q <= 1'b0;
                    if (rel_pong) valid_pong_q <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (KT != '0) begin
                                kt_q          <= KT;
                                fill_idx_q    <= '0;
                                fill_bank_q   <= 1'b0;
                                wait_cycles_q <= '0;
                                state_q       <= ISSUE;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (target_valid) begin
                            wait_cycles_q <= wait_cycles_d;
                        end else begin
                            fill_req_q <= 1'b1;
                            state_q    <= WAIT_FILL;
                        end
                    end
                    WAIT_FILL: begin
                        if (fill_done) begin
                            fill_req_q <= 1'b0;
                            if (fill_bank_q) valid_pong_q <= 1'b1;
                            else             valid_ping_q <= 1'b1;
                            fill_idx_q  <= fill_idx_d;
                            fill_bank_q <= ~fill_bank_q;
                            state_q     <= (fill_idx_d == kt_q) ? DRAIN : ISSUE;
                        end
                    end
                    DRAIN: begin
                        if (!valid_ping_q && !valid_pong_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef PPFC_PROTOCOL_CHECK_EN
    logic proto_err_q;
    logic proto_viol;
    logic start_accepted;

    // A violation is a release of an empty bank, a loader completion with
    // no request outstanding, or a start while a sequence is running.
    always_comb begin
        proto_viol = (rel_ping && !valid_ping_q) ||
                     (rel_pong && !valid_pong_q) ||
                     (fill_done && state_q != WAIT_FILL) ||
                     (start && state_q != IDLE);
        start_accepted = start && !abort && state_q == IDLE;
    end

    // Sticky flag: an accepted start clears it, but a violation seen in the
    // same cycle still sets it so that no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= (start_accepted ? 1'b0 : proto_err_q) | proto_viol;
        end
    end

    assign proto_err = proto_err_q;
`endif

    assign fill_req    = fill_req_q;
    assign fill_bank   = fill_bank_q;
    assign fill_idx    = fill_idx_q;
    assign valid_ping  = valid_ping_q;
    assign valid_pong  = valid_pong_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign wait_cycles = wait_cycles_q;

endmodule

// File: tb/tb_pingpong_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_fill_ctrl
//
// Directed, table-driven bench for pingpong_fill_ctrl. Each table row holds
// the inputs for one clock cycle and the outputs expected just after that
// edge. Hand-written sequences cover index wrap-around at the maximum KT and,
// when PPFC_PROTOCOL_CHECK_EN is defined, the sticky proto_err flag.
// ---------------------------------------------------------------------------
module tb_pingpong_fill_ctrl;

    localparam int KT_W  = 12;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [KT_W-1:0]  KT;
    logic             fill_req;
    logic             fill_bank;
    logic [KT_W-1:0]  fill_idx;
    logic             fill_done;
    logic             rel_ping;
    logic             rel_pong;
    logic             valid_ping;
    logic             valid_pong;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] wait_cycles;
`ifdef PPFC_PROTOCOL_CHECK_EN
    logic             proto_err;
`endif

    int errorCount;
    int checkCount;

    pingpong_fill_ctrl #(.KT_W(KT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .KT         (KT),
        .fill_req   (fill_req),
        .fill_bank  (fill_bank),
        .fill_idx   (fill_idx),
        .fill_done  (fill_done),
        .rel_ping   (rel_ping),
        .rel_pong   (rel_pong),
        .valid_ping (valid_ping),
        .valid_pong (valid_pong),
        .busy       (busy),
        .done       (done),
        .wait_cycles(wait_cycles)
`ifdef PPFC_PROTOCOL_CHECK_EN
        ,
        .proto_err  (proto_err)
`endif
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            rst;
        logic            start;
        logic            abort;
        logic [KT_W-1:0] kt;
        logic            fillDone;
        logic            relPing;
        logic            relPong;
        logic            eReq;
        logic            eBank;
        logic [KT_W-1:0] eIdx;
        logic            eVping;
        logic            eVpong;
        logic            eBusy;
        logic            eDone;
        logic [31:0]     eWait;
    } vec_t;

    vec_t vecs[$];

    // Builds one table row: inputs first, then expected outputs after the edge.
    function automatic vec_t mkVec(input logic r, input logic s, input logic a, input int kt,
                                   input logic fd, input logic rp, input logic rq,
                                   input logic eq, input logic eb, input int ei,
                                   input logic evp, input logic evq, input logic eby,
                                   input logic edn, input int ew);
        vec_t v;
        v.rst = r;  v.start = s;  v.abort = a;  v.kt = kt[KT_W-1:0];
        v.fillDone = fd;  v.relPing = rp;  v.relPong = rq;
        v.eReq = eq;  v.eBank = eb;  v.eIdx = ei[KT_W-1:0];
        v.eVping = evp;  v.eVpong = evq;  v.eBusy = eby;  v.eDone = edn;
        v.eWait = ew;
        return v;
    endfunction

    // Compares one observed value against the bench's expectation.
    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    // Advances one clock and settles just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one row's inputs for a cycle and compares every output after the edge.
    task automatic applyStimulus(input vec_t v, input int row);
        rst       = v.rst;
        start     = v.start;
        abort     = v.abort;
        KT        = v.kt;
        fill_done = v.fillDone;
        rel_ping  = v.relPing;
        rel_pong  = v.relPong;
        tick();
        checkOutput($sformatf("row%0d fill_req", row),    32'(fill_req),   32'(v.eReq));
        checkOutput($sformatf("row%0d fill_bank", row),   32'(fill_bank),  32'(v.eBank));
        checkOutput($sformatf("row%0d fill_idx", row),    32'(fill_idx),   32'(v.eIdx));
        checkOutput($sformatf("row%0d valid_ping", row),  32'(valid_ping), 32'(v.eVping));
        checkOutput($sformatf("row%0d valid_pong", row),  32'(valid_pong), 32'(v.eVpong));
        checkOutput($sformatf("row%0d busy", row),        32'(busy),       32'(v.eBusy));
        checkOutput($sformatf("row%0d done", row),        32'(done),       32'(v.eDone));
        checkOutput($sformatf("row%0d wait_cycles", row), wait_cycles,     v.eWait);
    endtask

    task automatic clearInputs();
        rst = 1'b0; start = 1'b0; abort = 1'b0; KT = '0;
        fill_done = 1'b0; rel_ping = 1'b0; rel_pong = 1'b0;
    endtask

    initial begin
        int row;
        int budget;
        bit sawDone;
        errorCount = 0;
        checkCount = 0;
        clearInputs();

        //               rst s a kt  fd rp rq  req bk idx vp vq by dn wait
        // Reset
        vecs.push_back(mkVec(1,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0));
        // KT=4, loader answers on the 2nd request cycle, each bank released 3 cycles after it fills
        vecs.push_back(mkVec(0,1,0,4, 0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,1,0, 0,0,2, 0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,2, 0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,2, 0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,1, 0,1,3, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,3, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,3, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,1,0, 0,0,4, 0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,4, 0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,4, 0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,1, 0,0,4, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,4, 0,0,0,1,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,4, 0,0,0,0,0));
        // KT=3, no releases: stall in ISSUE, then rel_ping lets (0,2) issue two edges later
        vecs.push_back(mkVec(0,1,0,3, 0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,0,2, 1,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,2, 1,1,1,0,1));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,2, 1,1,1,0,2));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,2, 1,1,1,0,3));
        vecs.push_back(mkVec(0,0,0,0, 0,1,0, 0,0,2, 0,1,1,0,4));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,2, 0,1,1,0,4));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,3, 1,1,1,0,4));
        vecs.push_back(mkVec(0,0,0,0, 0,1,1, 0,1,3, 0,0,1,0,4));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,1,3, 0,0,0,1,4));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,1,3, 0,0,0,0,4));
        // KT=0: done next cycle, never busy, no request
        vecs.push_back(mkVec(0,1,0,0, 0,0,0, 0,1,3, 0,0,0,1,4));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,1,3, 0,0,0,0,4));
        // Abort in WAIT_FILL at idx 1, then a clean KT=2 run
        vecs.push_back(mkVec(0,1,0,3, 0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,1,0, 0,0,0, 0,1,1, 0,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,1,1, 0,0,0,0,0));
        vecs.push_back(mkVec(0,1,0,2, 0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,0,2, 1,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,1,1, 0,0,2, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,2, 0,0,0,1,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,2, 0,0,0,0,0));
        // Release of both banks while ISSUE targets ping (stray fill_done ignored),
        // start while busy ignored, abort beats start, reset mid-stall clears wait_cycles
        vecs.push_back(mkVec(0,1,0,4, 0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,0,2, 1,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,1,1, 0,0,2, 0,0,1,0,1));
        vecs.push_back(mkVec(0,1,0,0, 0,0,0, 1,0,2, 0,0,1,0,1));
        vecs.push_back(mkVec(0,0,1,0, 0,0,0, 0,0,2, 0,0,0,0,1));
        vecs.push_back(mkVec(0,1,1,2, 0,0,0, 0,0,2, 0,0,0,0,1));
        vecs.push_back(mkVec(0,1,0,3, 0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,0,0, 0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 1,1,1, 1,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,0, 0,0,2, 1,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0, 0,0,2, 1,1,1,0,1));
        vecs.push_back(mkVec(1,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0));

        row = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], row);
            row++;
        end
        clearInputs();

        // Maximum KT: indices run 0 .. 2^KT_W-2, banks alternate, each bank
        // released right after it fills so the controller never stalls.
        start = 1'b1;
        KT    = '1;
        tick();
        start = 1'b0;
        for (int i = 0; i < (1 << KT_W) - 1; i++) begin
            logic [31:0] iv;
            iv = i;
            budget = 0;
            while (!fill_req && budget < 10) begin
                tick();
                budget++;
            end
            if (!fill_req) begin
                checkOutput($sformatf("wrap fill_req timeout idx%0d", i), 32'(fill_req), 32'd1);
                break;
            end
            if (fill_idx !== iv[KT_W-1:0] || fill_bank !== iv[0] || i == (1 << KT_W) - 2 || i == 0) begin
                checkOutput($sformatf("wrap fill_idx %0d", i), 32'(fill_idx), iv);
                checkOutput($sformatf("wrap fill_bank %0d", i), 32'(fill_bank), 32'(iv[0]));
            end
            fill_done = 1'b1;
            tick();
            fill_done = 1'b0;
            if (iv[0]) rel_pong = 1'b1;
            else       rel_ping = 1'b1;
            tick();
            rel_ping = 1'b0;
            rel_pong = 1'b0;
        end
        sawDone = done;
        budget  = 0;
        while (!sawDone && budget < 10) begin
            tick();
            sawDone = done;
            budget++;
        end
        checkOutput("wrap done pulse", 32'(sawDone), 32'd1);
        checkOutput("wrap wait_cycles", wait_cycles, 32'd0);
        tick();
        checkOutput("wrap busy after done", 32'(busy), 32'd0);

`ifdef PPFC_PROTOCOL_CHECK_EN
        // Sticky protocol error: set by releasing an empty bank, cleared by a start.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("proto_err after reset", 32'(proto_err), 32'd0);
        rel_pong = 1'b1;
        tick();
        rel_pong = 1'b0;
        checkOutput("proto_err set", 32'(proto_err), 32'd1);
        tick();
        checkOutput("proto_err held", 32'(proto_err), 32'd1);
        start = 1'b1;
        KT    = '0;
        tick();
        start = 1'b0;
        checkOutput("proto_err cleared by start", 32'(proto_err), 32'd0);
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        checkOutput("proto_err stray fill_done", 32'(proto_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
